// File: rtl/stream_mux_rr_if.sv
// Stream bundle between the N-channel sources and the single muxed output of stream_mux_rr.
// slave = the mux itself, master = whatever drives the sources and sinks the output.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(N_CH)
) ();
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic [SW-1:0]         out_ch;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Packet-locked stream multiplexer: grants one channel (fixed select or round-robin) until its
// last beat passes, with a single registered output stage and a packet counter.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(N_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    stream_mux_rr_if.slave bus,
    output logic [15:0]    pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg;
    logic [SW-1:0]    gnt_reg;
    logic [SW-1:0]    ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic [SW-1:0]    out_ch_reg;
    logic [15:0]      pkt_cnt_reg;

    logic             busy;
    logic             out_free;
    logic             in_hs;
    logic             out_hs;
    logic             cur_valid;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             fix_req;
    logic [2*N_CH-1:0] rr_dbl;
    logic [N_CH-1:0]  rr_rot;
    logic             rr_req;
    logic [SW-1:0]    rr_gnt;
    logic [N_CH-1:0]  ready_vec;

    // Map "offset from ptr+1" back to a channel index; v never reaches 2*N_CH.
    function automatic logic [SW-1:0] wrap_idx(input int v);
        if (v >= N_CH) begin
            return SW'(v - N_CH);
        end
        return SW'(v);
    endfunction

    assign busy     = (state_reg == BUSY);
    assign out_free = !out_valid_reg || bus.out_ready;
    assign in_hs    = busy && cur_valid && out_free;
    assign out_hs   = out_valid_reg && bus.out_ready;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_reg == SW'(k)) begin
                cur_valid = bus.in_valid[k];
                cur_last  = bus.in_last[k];
                cur_data  = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Out-of-range sel values match no k, so they can never request a grant.
    always_comb begin
        fix_req = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if ((sel == SW'(k)) && bus.in_valid[k]) begin
                fix_req = 1'b1;
            end
        end
    end

    // Rotate the request vector so bit j is channel (ptr+1+j) mod N_CH; the lowest set bit wins.
    always_comb begin
        rr_dbl = {bus.in_valid, bus.in_valid} >> ({1'b0, ptr_reg} + (SW+1)'(1));
        rr_rot = rr_dbl[N_CH-1:0];
        rr_req = |rr_rot;
        rr_gnt = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rr_rot[j]) begin
                rr_gnt = wrap_idx(int'(ptr_reg) + 1 + j);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign ready_vec[gi] = busy && (gnt_reg == SW'(gi)) && out_free;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            ptr_reg       <= SW'(N_CH - 1);
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
            pkt_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!mode) begin
                        if (fix_req) begin
                            gnt_reg   <= sel;
                            state_reg <= BUSY;
                        end
                    end else if (rr_req) begin
                        gnt_reg   <= rr_gnt;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    // The lock is held until the granted channel's last beat is taken.
                    if (in_hs && cur_last) begin
                        state_reg <= IDLE;
                        ptr_reg   <= gnt_reg;
                    end
                end
            endcase

            if (in_hs) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= cur_data;
                out_last_reg  <= cur_last;
                out_ch_reg    <= gnt_reg;
            end else if (out_hs) begin
                out_valid_reg <= 1'b0;
            end

            if (out_hs && out_last_reg) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_ch    = out_ch_reg;
    assign pkt_cnt       = pkt_cnt_reg;

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, range 2..16.
REQ-002 Parameter WIDTH, default 8: data bits per channel.
REQ-003 Parameter SW, default $clog2(N_CH): select and channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 mode  input  1  0 = fixed select via sel, 1 = round-robin.
REQ-007 sel  input  SW  channel to grant in fixed mode.
REQ-008 in_valid  input  N_CH  per-channel beat valid.
REQ-009 in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_last  input  N_CH  per-channel last beat of packet.
REQ-011 in_ready  output  N_CH  per-channel beat accepted when in_valid[k] and in_ready[k] are both high.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_data  output  WIDTH  output beat data.
REQ-014 out_last  output  1  output beat is last of packet.
REQ-015 out_ch  output  SW  source channel of output beat.
REQ-016 out_ready  input  1  downstream accepts beat when out_valid and out_ready are both high.
REQ-017 pkt_cnt  output  16  count of packets completed at output (out_last beats accepted); wraps 0xFFFF->0x0000.

Function
REQ-018 FSM states are IDLE and BUSY; the registered grant index is gnt.
REQ-019 In IDLE, fixed mode: if sel < N_CH and in_valid[sel] is high, gnt<=sel and state<=BUSY; otherwise the FSM stays in IDLE.
REQ-020 In IDLE, round-robin mode: gnt<=first k with in_valid[k] high, searching ptr+1, ptr+2, ... modulo N_CH; state<=BUSY; with no valid channel the FSM stays in IDLE.
REQ-021 mode and sel are sampled only in IDLE; changes during BUSY are ignored until the FSM returns to IDLE.
REQ-022 in_ready[k] = (state==BUSY) && (k==gnt) && (!out_valid || out_ready), combinational; all other bits are 0.
REQ-023 On an input handshake, out_data, out_last and out_ch (=gnt) are loaded and out_valid<=1 at the next edge.
REQ-024 If out_valid && out_ready and there is no input handshake, out_valid<=0 at the next edge.
REQ-025 While out_valid && !out_ready, out_data, out_last and out_ch hold stable.
REQ-026 On a handshake with in_last[gnt] high, state<=IDLE and ptr<=gnt at the next edge (packet lock released).
REQ-027 A packet is never interleaved; other channels' in_valid is ignored while BUSY.
REQ-028 Latency: in_valid rising in IDLE at edge t gives in_ready at t+1 and out_valid at t+2; there is 1 idle cycle between consecutive packets.
REQ-029 Full throughput within a packet: 1 beat/cycle when out_ready is held high.
REQ-030 pkt_cnt increments by 1 on each output handshake with out_last high.
REQ-031 Non-granted in_valid does not need to be held by the block; sources SHALL hold data stable until their handshake.

Reset
REQ-032 When rst_n is low at an edge: state<=IDLE, gnt<=0, ptr<=N_CH-1, out_valid<=0, out_data<=0, out_last<=0, out_ch<=0, pkt_cnt<=0.
REQ-033 Reset mid-packet discards the packet in flight, with no partial output after reset; in_ready is 0 in the cycle after reset.

Verification
REQ-034 N_CH=4, WIDTH=8, mode=0, sel=2, out_ready=1; ch2 sends 0xA1, 0xA2, 0xA3 (last) -> out_data A1, A2, A3 on consecutive cycles, out_ch=2, out_last only on A3, pkt_cnt=1.
REQ-035 mode=1, all 4 channels repeatedly send 1-beat packets -> out_ch order 0, 1, 2, 3, 0, 1 with one idle cycle between beats.
REQ-036 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data stable, in_ready[gnt]=0, and every beat arrives exactly once in order.
REQ-037 Lock: mode=1, ch1 in a 4-beat packet, ch0 asserts in_valid at beat 2 -> ch0 is granted only after ch1's last beat, and no ch0 beat appears inside the ch1 packet.
REQ-038 rst_n low for 1 cycle during beat 2 of a packet -> the next cycle has out_valid=0, pkt_cnt=0, in_ready=0; the next grant in RR mode starts from ch0.
REQ-039 N_CH=3, mode=0, sel=3, all in_valid high -> no grant, in_ready=0 and out_valid=0 for 10 cycles.
